// File: rtl/spi_sck_sequencer_pkg.sv
// Shared types and defaults for the SPI SCK/CS frame sequencer.
package spi_sck_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    localparam int DEF_DIV_WIDTH = 16;
    localparam int DEF_CNT_WIDTH = 8;
    localparam int DEF_DLY_WIDTH = 8;
    localparam int DEF_CS_NUM    = 4;

    // One spare bit beyond the line index so out-of-range selects can be expressed.
    function automatic int sel_width(input int cs_num);
        return $clog2(cs_num) + 1;
    endfunction

endpackage

// File: rtl/spi_sck_sequencer_if.sv
// Register-block side configuration/handshake and shifter-side SPI outputs of the sequencer.
interface spi_sck_sequencer_if #(
    parameter int DIV_WIDTH = spi_sck_sequencer_pkg::DEF_DIV_WIDTH,
    parameter int CNT_WIDTH = spi_sck_sequencer_pkg::DEF_CNT_WIDTH,
    parameter int DLY_WIDTH = spi_sck_sequencer_pkg::DEF_DLY_WIDTH,
    parameter int CS_NUM    = spi_sck_sequencer_pkg::DEF_CS_NUM
);
    localparam int SEL_W = spi_sck_sequencer_pkg::sel_width(CS_NUM);

    logic                 en_i;
    logic                 start_i;
    logic                 cpol_i;
    logic                 cpha_i;
    logic [DIV_WIDTH-1:0] clk_div_i;
    logic [CNT_WIDTH-1:0] nbits_i;
    logic [SEL_W-1:0]     cs_sel_i;
    logic [DLY_WIDTH-1:0] setup_i;
    logic [DLY_WIDTH-1:0] hold_i;
    logic [DLY_WIDTH-1:0] gap_i;
    logic                 sck_o;
    logic [CS_NUM-1:0]    cs_n_o;
    logic                 shift_o;
    logic                 sample_o;
    logic                 pos_edge_o;
    logic                 neg_edge_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        output en_i, start_i, cpol_i, cpha_i, clk_div_i, nbits_i, cs_sel_i,
               setup_i, hold_i, gap_i,
        input  sck_o, cs_n_o, shift_o, sample_o, pos_edge_o, neg_edge_o, busy_o, done_o
    );

    modport slave (
        input  en_i, start_i, cpol_i, cpha_i, clk_div_i, nbits_i, cs_sel_i,
               setup_i, hold_i, gap_i,
        output sck_o, cs_n_o, shift_o, sample_o, pos_edge_o, neg_edge_o, busy_o, done_o
    );

endinterface

// File: rtl/spi_sck_sequencer_clk_div.sv
// Half-period tick generator: down-counter that ticks at zero and reloads, period div+1.
module spi_sck_sequencer_clk_div #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == {DIV_WIDTH{1'b0}});

    // Next count: explicit load wins, then reload on tick, else count down while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = div_i;
        end else if (tick_o) begin
            cnt_d = div_i;
        end else if (en_i) begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= {DIV_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_sck_sequencer.sv
// SPI master frame sequencer: CS setup/hold/gap phases around 2*(nbits+1) SCK toggles,
// with registered shift/sample and edge strobes aligned to each SCK change.
module spi_sck_sequencer
    import spi_sck_sequencer_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int DLY_WIDTH = DEF_DLY_WIDTH,
    parameter int CS_NUM    = DEF_CS_NUM
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    spi_sck_sequencer_if.slave spi
);
    localparam int SEL_W = sel_width(CS_NUM);
    localparam int TOG_W = CNT_WIDTH + 1;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [CNT_WIDTH-1:0] nbits_q, nbits_d;
    logic [DLY_WIDTH-1:0] hold_q, hold_d;
    logic [DLY_WIDTH-1:0] gap_q, gap_d;
    logic [DLY_WIDTH-1:0] dly_q, dly_d;
    logic [TOG_W-1:0]     tog_q, tog_d;
    logic                 cpha_q, cpha_d;
    logic                 sck_q, sck_d;
    logic [CS_NUM-1:0]    cs_n_q, cs_n_d;
    logic                 shift_q, shift_d;
    logic                 sample_q, sample_d;
    logic                 pos_q, pos_d;
    logic                 neg_q, neg_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 accept_s;
    logic                 tick_s;
    logic                 div_en_s;
    logic [DIV_WIDTH-1:0] div_load_s;
    logic                 last_tog_s;
    logic                 lead_s;
    logic                 dly_last_s;
    logic [CS_NUM-1:0]    cs_dec_s;

    // A start coinciding with the done pulse is dropped; the next cycle may accept it.
    assign accept_s   = (state_q == ST_IDLE) && spi.en_i && spi.start_i && !done_q;
    assign div_en_s   = (state_q != ST_IDLE) && spi.en_i;
    assign div_load_s = accept_s ? spi.clk_div_i : div_q;
    assign last_tog_s = (tog_q == {nbits_q, 1'b1});
    assign lead_s     = ~tog_q[0];
    assign dly_last_s = (dly_q == DLY_WIDTH'(1));

    spi_sck_sequencer_clk_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clk_div (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (accept_s),
        .en_i    (div_en_s),
        .div_i   (div_load_s),
        .tick_o  (tick_s)
    );

    // Active-low one-hot decode of the requested chip select; out-of-range selects none.
    always_comb begin
        cs_dec_s = {CS_NUM{1'b1}};
        for (int i = 0; i < CS_NUM; i++) begin
            if (spi.cs_sel_i == SEL_W'(i)) begin
                cs_dec_s[i] = 1'b0;
            end else begin
                cs_dec_s[i] = 1'b1;
            end
        end
    end

    // Phase sequencing and next values of every registered output.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        nbits_d  = nbits_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        cpha_d   = cpha_q;
        dly_d    = dly_q;
        tog_d    = tog_q;
        sck_d    = sck_q;
        cs_n_d   = cs_n_q;
        busy_d   = busy_q;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        pos_d    = 1'b0;
        neg_d    = 1'b0;
        done_d   = 1'b0;
        if (!spi.en_i) begin
            state_d = ST_IDLE;
            sck_d   = spi.cpol_i;
            cs_n_d  = {CS_NUM{1'b1}};
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sck_d = spi.cpol_i;
                    if (accept_s) begin
                        div_d   = spi.clk_div_i;
                        nbits_d = spi.nbits_i;
                        hold_d  = spi.hold_i;
                        gap_d   = spi.gap_i;
                        cpha_d  = spi.cpha_i;
                        dly_d   = spi.setup_i;
                        tog_d   = {TOG_W{1'b0}};
                        cs_n_d  = cs_dec_s;
                        busy_d  = 1'b1;
                        state_d = (spi.setup_i != {DLY_WIDTH{1'b0}}) ? ST_SETUP : ST_XFER;
                    end else begin
                        cs_n_d = {CS_NUM{1'b1}};
                        busy_d = 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (tick_s && dly_last_s) begin
                        state_d = ST_XFER;
                    end else if (tick_s) begin
                        dly_d = dly_q - DLY_WIDTH'(1);
                    end else begin
                        dly_d = dly_q;
                    end
                end
                ST_XFER: begin
                    if (tick_s) begin
                        sck_d = ~sck_q;
                        pos_d = ~sck_q;
                        neg_d = sck_q;
                        tog_d = tog_q + TOG_W'(1);
                        // The final trailing edge has no following bit to shift out.
                        if (lead_s) begin
                            sample_d = ~cpha_q;
                            shift_d  = cpha_q;
                        end else begin
                            sample_d = cpha_q;
                            shift_d  = ~cpha_q & ~last_tog_s;
                        end
                        if (last_tog_s) begin
                            if (hold_q != {DLY_WIDTH{1'b0}}) begin
                                state_d = ST_HOLD;
                                dly_d   = hold_q;
                            end else if (gap_q != {DLY_WIDTH{1'b0}}) begin
                                state_d = ST_GAP;
                                dly_d   = gap_q;
                                cs_n_d  = {CS_NUM{1'b1}};
                            end else begin
                                state_d = ST_IDLE;
                                cs_n_d  = {CS_NUM{1'b1}};
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            state_d = ST_XFER;
                        end
                    end else begin
                        sck_d = sck_q;
                    end
                end
                ST_HOLD: begin
                    if (tick_s && dly_last_s) begin
                        cs_n_d = {CS_NUM{1'b1}};
                        if (gap_q != {DLY_WIDTH{1'b0}}) begin
                            state_d = ST_GAP;
                            dly_d   = gap_q;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else if (tick_s) begin
                        dly_d = dly_q - DLY_WIDTH'(1);
                    end else begin
                        dly_d = dly_q;
                    end
                end
                ST_GAP: begin
                    if (tick_s && dly_last_s) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (tick_s) begin
                        dly_d = dly_q - DLY_WIDTH'(1);
                    end else begin
                        dly_d = dly_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cs_n_d  = {CS_NUM{1'b1}};
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, latched frame configuration and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            div_q    <= {DIV_WIDTH{1'b0}};
            nbits_q  <= {CNT_WIDTH{1'b0}};
            hold_q   <= {DLY_WIDTH{1'b0}};
            gap_q    <= {DLY_WIDTH{1'b0}};
            cpha_q   <= 1'b0;
            dly_q    <= {DLY_WIDTH{1'b0}};
            tog_q    <= {TOG_W{1'b0}};
            sck_q    <= 1'b0;
            cs_n_q   <= {CS_NUM{1'b1}};
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            pos_q    <= 1'b0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            nbits_q  <= nbits_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
            cpha_q   <= cpha_d;
            dly_q    <= dly_d;
            tog_q    <= tog_d;
            sck_q    <= sck_d;
            cs_n_q   <= cs_n_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            pos_q    <= pos_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign spi.sck_o      = sck_q;
    assign spi.cs_n_o     = cs_n_q;
    assign spi.shift_o    = shift_q;
    assign spi.sample_o   = sample_q;
    assign spi.pos_edge_o = pos_q;
    assign spi.neg_edge_o = neg_q;
    assign spi.busy_o     = busy_q;
    assign spi.done_o     = done_q;

endmodule

// File: tb/tb_spi_sck_sequencer.sv
// Directed self-checking bench for spi_sck_sequencer; cycle offsets are hand-derived.
module tb_spi_sck_sequencer;
    localparam int DW  = 16;
    localparam int CW  = 8;
    localparam int LW  = 8;
    localparam int CSN = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    int   f_tog, f_shift, f_sample, f_pos, f_neg, f_sample_hi, f_shift_lo;
    int   f_bad_edge, f_bad_cs, f_done, f_busy_done;
    int   f_cs_low_k, f_cs_high_k, f_first_k, f_last_k, f_done_k;
    logic f_busy_k1;
    logic [CSN-1:0] f_cs_and;

    spi_sck_sequencer_if #(.DIV_WIDTH(DW), .CNT_WIDTH(CW), .DLY_WIDTH(LW), .CS_NUM(CSN)) spi();

    spi_sck_sequencer #(.DIV_WIDTH(DW), .CNT_WIDTH(CW), .DLY_WIDTH(LW), .CS_NUM(CSN)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .spi     (spi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic cpol, input logic cpha, input int div, input int nbits,
                       input int sel, input int setup, input int hold, input int gap);
        spi.cpol_i    = cpol;
        spi.cpha_i    = cpha;
        spi.clk_div_i = DW'(div);
        spi.nbits_i   = CW'(nbits);
        spi.cs_sel_i  = 3'(sel);
        spi.setup_i   = LW'(setup);
        spi.hold_i    = LW'(hold);
        spi.gap_i     = LW'(gap);
    endtask

    // k = 1 is the first falling edge after the accepting rising edge.
    task automatic run_frame(input int budget, input bit hold_start);
        logic prev_sck;
        logic chg;
        f_tog = 0; f_shift = 0; f_sample = 0; f_pos = 0; f_neg = 0;
        f_sample_hi = 0; f_shift_lo = 0; f_bad_edge = 0; f_bad_cs = 0;
        f_done = 0; f_busy_done = 0;
        f_cs_low_k = -1; f_cs_high_k = -1; f_first_k = -1; f_last_k = -1; f_done_k = -1;
        f_busy_k1 = 1'b0;
        f_cs_and = '1;
        @(negedge clk);
        spi.start_i = 1'b1;
        prev_sck = spi.sck_o;
        for (int k = 1; k <= budget && f_done == 0; k++) begin
            @(negedge clk);
            if (!hold_start) spi.start_i = 1'b0;
            if (k == 1) f_busy_k1 = spi.busy_o;
            f_cs_and = f_cs_and & spi.cs_n_o;
            if ($countones(~spi.cs_n_o) > 1) f_bad_cs++;
            if (spi.cs_n_o != '1 && f_cs_low_k < 0) f_cs_low_k = k;
            if (spi.cs_n_o == '1 && f_cs_low_k >= 0 && f_cs_high_k < 0) f_cs_high_k = k;
            chg = (spi.sck_o !== prev_sck);
            if (chg) begin
                f_tog++;
                if (f_first_k < 0) f_first_k = k;
                f_last_k = k;
            end
            if (spi.pos_edge_o !== (chg && spi.sck_o)) f_bad_edge++;
            if (spi.neg_edge_o !== (chg && !spi.sck_o)) f_bad_edge++;
            if ((spi.shift_o || spi.sample_o) && !chg) f_bad_edge++;
            if (spi.shift_o) f_shift++;
            if (spi.sample_o) f_sample++;
            if (spi.pos_edge_o) f_pos++;
            if (spi.neg_edge_o) f_neg++;
            if (spi.sample_o && spi.sck_o) f_sample_hi++;
            if (spi.shift_o && !spi.sck_o) f_shift_lo++;
            if (spi.done_o) begin
                f_done++;
                f_done_k = k;
                if (spi.busy_o !== 1'b0) f_busy_done++;
            end
            prev_sck = spi.sck_o;
        end
        chk("frame_completed", f_done, 1);
    endtask

    task automatic idle_watch(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (spi.busy_o !== 1'b0 || spi.done_o !== 1'b0 || spi.cs_n_o !== '1) hits++;
        end
    endtask

    initial begin
        int hits;
        int w;
        rst_n = 1'b0;
        spi.en_i = 1'b1;
        spi.start_i = 1'b0;
        cfg(1'b1, 1'b0, 0, 7, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        // Reset state with cpol_i=1: sck must still be 0.
        chk("reset_outs", {spi.sck_o, spi.cs_n_o, spi.shift_o, spi.sample_o, spi.pos_edge_o,
                           spi.neg_edge_o, spi.busy_o, spi.done_o}, {1'b0, 4'hF, 6'b0});
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_sck_follows_cpol", spi.sck_o, 1'b1);

        // A: cpol0 cpha0 div0 nbits7, no delays.
        cfg(1'b0, 1'b0, 0, 7, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        run_frame(100, 1'b0);
        chk("a_busy_after_accept", f_busy_k1, 1'b1);
        chk("a_cs_low_k", f_cs_low_k, 1);
        chk("a_first_edge_k", f_first_k, 2);
        chk("a_toggles", f_tog, 16);
        chk("a_last_edge_k", f_last_k, 17);
        chk("a_done_k", f_done_k, 17);
        chk("a_cs_high_k", f_cs_high_k, 17);
        chk("a_samples", f_sample, 8);
        chk("a_sample_on_rise", f_sample_hi, 8);
        chk("a_shifts", f_shift, 7);
        chk("a_pos", f_pos, 8);
        chk("a_neg", f_neg, 8);
        chk("a_strobe_align", f_bad_edge, 0);
        chk("a_cs_and", f_cs_and, 4'b1110);
        chk("a_busy_at_done", f_busy_done, 0);
        idle_watch(5, hits);
        chk("a_quiet_after", hits, 0);

        // B: cpol1 cpha1 div3 nbits3; check 1-cycle cpol lag first.
        @(negedge clk);
        cfg(1'b1, 1'b1, 3, 3, 1, 0, 0, 0);
        chk("b_cpol_lag_before", spi.sck_o, 1'b0);
        @(negedge clk);
        chk("b_cpol_lag_after", spi.sck_o, 1'b1);
        run_frame(100, 1'b0);
        chk("b_first_edge_k", f_first_k, 5);
        chk("b_last_edge_k", f_last_k, 33);
        chk("b_toggles", f_tog, 8);
        chk("b_shift_on_fall", f_shift_lo, 4);
        chk("b_shifts", f_shift, 4);
        chk("b_sample_on_rise", f_sample_hi, 4);
        chk("b_samples", f_sample, 4);
        chk("b_done_k", f_done_k, 33);
        chk("b_sck_end_cpol", spi.sck_o, 1'b1);
        chk("b_cs_and", f_cs_and, 4'b1101);
        chk("b_strobe_align", f_bad_edge, 0);

        // C: setup2 hold1 gap3 div1 nbits1.
        cfg(1'b0, 1'b0, 1, 1, 0, 2, 1, 3);
        repeat (2) @(negedge clk);
        run_frame(100, 1'b0);
        chk("c_cs_low_to_edge", f_first_k - f_cs_low_k, 6);
        chk("c_edge_to_cs_high", f_cs_high_k - f_last_k, 2);
        chk("c_cs_high_to_done", f_done_k - f_cs_high_k, 6);
        chk("c_toggles", f_tog, 4);
        chk("c_shifts", f_shift, 1);
        chk("c_samples", f_sample, 2);

        // D: chip-select decode, in range and out of range.
        cfg(1'b0, 1'b0, 0, 0, 2, 0, 0, 0);
        run_frame(50, 1'b0);
        chk("d_sel2_cs_and", f_cs_and, 4'b1011);
        chk("d_sel2_one_hot", f_bad_cs, 0);
        cfg(1'b0, 1'b0, 0, 0, 5, 0, 0, 0);
        run_frame(50, 1'b0);
        chk("d_sel5_cs_and", f_cs_and, 4'b1111);
        chk("d_sel5_toggles", f_tog, 2);
        chk("d_sel5_done_k", f_done_k, 3);

        // E: abort during bit 3 with div2; SCK would still be high without the abort.
        cfg(1'b0, 1'b0, 2, 7, 3, 0, 0, 0);
        @(negedge clk);
        spi.start_i = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            spi.start_i = 1'b0;
        end
        chk("e_pre_abort_sck", spi.sck_o, 1'b1);
        chk("e_pre_abort_busy", spi.busy_o, 1'b1);
        spi.en_i = 1'b0;
        @(negedge clk);
        chk("e_abort_cs", spi.cs_n_o, 4'hF);
        chk("e_abort_busy", spi.busy_o, 1'b0);
        chk("e_abort_done", spi.done_o, 1'b0);
        chk("e_abort_sck", spi.sck_o, 1'b0);
        chk("e_abort_strobes", {spi.shift_o, spi.sample_o, spi.pos_edge_o, spi.neg_edge_o}, 4'b0);
        repeat (2) @(negedge clk);
        spi.en_i = 1'b1;
        idle_watch(40, hits);
        chk("e_no_resume", hits, 0);
        cfg(1'b0, 1'b0, 0, 7, 0, 0, 0, 0);
        run_frame(100, 1'b0);
        chk("e_restart_first_k", f_first_k, 2);
        chk("e_restart_toggles", f_tog, 16);
        chk("e_restart_done_k", f_done_k, 17);

        // F: start held high throughout; one frame, done-cycle start dropped, next accepted.
        run_frame(100, 1'b1);
        chk("f_toggles", f_tog, 16);
        chk("f_done_k", f_done_k, 17);
        @(negedge clk);
        chk("f_start_on_done_ignored", spi.busy_o, 1'b0);
        @(negedge clk);
        chk("f_start_next_accepted", spi.busy_o, 1'b1);
        spi.start_i = 1'b0;
        w = 0;
        while (spi.done_o !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("f_second_done", spi.done_o, 1'b1);

        // G: maximum frame length.
        cfg(1'b0, 1'b0, 0, 255, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        run_frame(600, 1'b0);
        chk("g_toggles", f_tog, 512);
        chk("g_done_k", f_done_k, 513);
        chk("g_shifts", f_shift, 255);
        chk("g_samples", f_sample, 256);

        // H: reset mid-frame with cpol=1.
        cfg(1'b1, 1'b0, 1, 7, 1, 0, 0, 0);
        repeat (2) @(negedge clk);
        spi.start_i = 1'b1;
        @(negedge clk);
        spi.start_i = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("h_reset_outs", {spi.sck_o, spi.cs_n_o, spi.shift_o, spi.sample_o, spi.pos_edge_o,
                             spi.neg_edge_o, spi.busy_o, spi.done_o}, {1'b0, 4'hF, 6'b0});
        rst_n = 1'b1;
        @(negedge clk);
        chk("h_post_reset_sck", spi.sck_o, 1'b1);
        idle_watch(30, hits);
        chk("h_quiet_after_reset", hits, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
